ifu_prefetch_queue: RTL and testbench
=====================================

// Module: ifu_prefetch_queue
// PURPOSE
//  Parametrised instruction-fetch unit. Replaces the single-shot "fetch on ALU_done" scheme
//  with a valid/ready memory request channel plus a DEPTH-entry prefetch FIFO. Sits between
//  the memory port (DPI-backed or bus) and decode. Supports redirect (branch/jump) with flush,
//  and carries bus errors to decode.
// PARAMETERS
//  XLEN      32            address width
//  ILEN      32            instruction width
//  DEPTH     4             prefetch FIFO entries, power of two, >=2
//  RESET_PC  32'h8000_0000 first fetch address after reset
// PORTS
//  clk            in   1     clock, all state on posedge
//  rst            in   1     reset
//  redirect_valid in   1     flush and restart fetch at redirect_pc
//  redirect_pc    in   XLEN  new fetch PC; bits [1:0] ignored (treated as 0)
//  mem_req_valid  out  1     fetch request valid
//  mem_req_ready  in   1     memory accepts request
//  mem_req_addr   out  XLEN  fetch address, word aligned
//  mem_rsp_valid  in   1     response valid, in request order, always accepted
//  mem_rsp_data   in   ILEN  fetched instruction
//  mem_rsp_err    in   1     access fault for this response
//  inst_valid     out  1     FIFO head valid
//  inst_ready     in   1     decode consumes head
//  inst           out  ILEN  head instruction
//  inst_pc        out  XLEN  head PC
//  inst_err       out  1     head carries fetch fault
// BEHAVIOUR
//  Reset rst, synchronous, active-high. Outputs at reset: mem_req_valid=0, inst_valid=0,
//   mem_req_addr=RESET_PC, inst/inst_pc/inst_err=0. fetch_pc=RESET_PC, FIFO empty, state IDLE.
//  One request outstanding at most. Request handshake = mem_req_valid & mem_req_ready.
//  FSM:
//   IDLE : if (count < DEPTH) -> REQ (mem_req_valid=1 next cycle). Credit counts the
//          outstanding slot: never issue when count==DEPTH.
//   REQ  : mem_req_valid=1, mem_req_addr=fetch_pc held stable until handshake.
//          On handshake: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps mod 2^XLEN) -> WAIT.
//   WAIT : on mem_rsp_valid push {req_pc,data,err}; err=0 -> IDLE, err=1 -> HALT.
//          Response may arrive the cycle after handshake at earliest (latency >=1).
//   DROP : outstanding response belongs to flushed stream; discard it on mem_rsp_valid -> IDLE.
//   HALT : no requests issued; leave only via redirect -> IDLE.
//  FIFO: push at most 1/cycle, pop when inst_valid & inst_ready; push and pop same cycle
//   legal at any count incl. full (count unchanged). Push while count==DEPTH cannot occur
//   (credit rule); assert in simulation. Head visible the cycle after push (1-cycle min
//   fetch-to-decode latency beyond memory latency).
//  Redirect (highest priority, same cycle as any other event):
//   - FIFO flushed (count=0, inst_valid=0 next cycle); concurrent pop ignored.
//   - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
//   - IDLE/HALT -> IDLE. WAIT -> DROP; WAIT with mem_rsp_valid same cycle -> response
//     discarded, -> IDLE. REQ without handshake -> request withdrawn (valid may drop),
//     -> IDLE. REQ with handshake same cycle -> DROP; fetch_pc not incremented.
//   - DROP with redirect: stay DROP (only one outstanding response), fetch_pc updated.
//  mem_rsp_valid outside WAIT/DROP is a protocol error; ignored, assert in simulation.
//  Reset mid-operation: all state to reset values next cycle; a response returning after
//   reset is ignored (state IDLE).
// TESTING
//  1 rst 2 cycles, ready=1, rsp latency 1 -> first req addr 0x8000_0000, then 0x..04,
//    0x..08; inst_pc sequence 0x8000_0000,0x8000_0004 with matching inst data.
//  2 inst_ready=0, DEPTH=4 -> exactly 4 rsps pushed, mem_req_valid stays 0; one pop ->
//    next req addr 0x8000_0010 issued.
//  3 redirect to 0x8000_0103 while WAIT -> in-flight rsp dropped, inst_valid=0, next
//    req addr 0x8000_0100, next inst_pc 0x8000_0100.
//  4 redirect same cycle as mem_rsp_valid and inst pop with FIFO=2 -> FIFO empty,
//    response not pushed, next req at redirect address.
//  5 rsp err=1 at 0x8000_0008 -> inst_err=1 with inst_pc 0x8000_0008, no further
//    requests for 20 cycles; redirect to 0x8000_0000 resumes fetch.
//  6 mem_req_ready=0 for 5 cycles -> addr stable; fetch_pc 0xFFFF_FFFC wraps to 0x0;
//    rst asserted in WAIT -> mem_req_valid=0, inst_valid=0, next req 0x8000_0000.

Source files
------------

// File: rtl/ifu_prefetch_queue.sv
// Instruction-fetch unit: valid/ready memory request channel feeding a DEPTH-entry
// prefetch FIFO toward decode, with redirect/flush and fault propagation.
module ifu_prefetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err
);

    localparam int unsigned  AW     = $clog2(DEPTH);
    localparam int unsigned  CW     = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDrop, StHalt} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [ILEN-1:0] data_mem [DEPTH];
    logic            err_mem  [DEPTH];

    logic hs, push, pop;

    assign hs   = mem_req_valid & mem_req_ready;
    // Redirect wins: a response landing in the redirect cycle belongs to the old stream.
    assign push = (state_q == StWait) & mem_rsp_valid & ~redirect_valid;
    assign pop  = inst_valid & inst_ready & ~redirect_valid;

    // State and pointer registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while the slot is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= req_pc_q;
            data_mem[wr_ptr_q] <= mem_rsp_data;
            err_mem[wr_ptr_q]  <= mem_rsp_err;
        end
    end

    // Next-state logic of the fetch FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (!redirect_valid && count_q < DepthC) state_d = StReq;
            StReq: begin
                if (hs)                  state_d = redirect_valid ? StDrop : StWait;
                else if (redirect_valid) state_d = StIdle;
            end
            StWait: begin
                if (mem_rsp_valid)       state_d = (mem_rsp_err && !redirect_valid) ? StHalt : StIdle;
                else if (redirect_valid) state_d = StDrop;
            end
            // Only one response can be owed, so a further redirect keeps us here.
            StDrop: if (mem_rsp_valid) state_d = StIdle;
            StHalt: if (redirect_valid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request-channel outputs decoded from the current state.
    always_comb begin
        mem_req_valid = (state_q == StReq);
        mem_req_addr  = fetch_pc_q;
    end

    // Fetch PC and in-flight request PC tracking.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (hs) req_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (hs) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    // FIFO pointer/occupancy update with flush on redirect.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Head-of-queue outputs, forced to zero while empty.
    always_comb begin
        inst_valid = (count_q != '0);
        inst       = inst_valid ? data_mem[rd_ptr_q] : '0;
        inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : '0;
        inst_err   = inst_valid ? err_mem[rd_ptr_q]  : 1'b0;
    end

`ifndef SYNTHESIS
    // Protocol checks: credit rule keeps the FIFO from overflowing; responses only when owed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && count_q == DepthC))
                else $error("ifu_prefetch_queue: push into full fifo");
            assert (!(mem_rsp_valid && state_q != StWait && state_q != StDrop))
                else $error("ifu_prefetch_queue: response with nothing outstanding");
        end
    end
`endif

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Bench for ifu_prefetch_queue: directed scenarios plus random traffic, every cycle
// checked against a transaction-level model (expected stream of PCs and FIFO contents).
module tb_ifu_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;

    always #5 clk = ~clk;

    ifu_prefetch_queue #(
        .XLEN    (32),
        .ILEN    (32),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_err      (inst_err)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } entry_t;

    // Reference model: expected FIFO contents and expected fetch stream.
    entry_t      m_fifo[$];
    logic [31:0] m_next_pc;
    logic [31:0] m_out_pc;
    bit          m_out, m_stale, m_halt;

    // Memory responder state.
    bit          pend;
    int          pend_wait;
    int          lat = 1;
    logic [31:0] rsp_addr;
    logic [31:0] err_addr = 32'h1;
    bit          rand_err = 1'b0;

    // Observations.
    logic [31:0] hs_log[$];
    entry_t      pop_log[$];

    // Stimulus for the next cycle.
    bit          redir = 1'b0;
    logic [31:0] redir_pc = '0;
    bit          ready_in = 1'b0;
    bit          iready_in = 1'b0;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a == err_addr) || (rand_err && a[7:2] == 6'h15);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic step();
        bit     rv, hs, pop;
        entry_t e;
        rv = pend && (pend_wait == 0);
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        mem_req_ready  = ready_in;
        inst_ready     = iready_in;
        mem_rsp_valid  = rv;
        mem_rsp_data   = rv ? mem_data(rsp_addr) : '0;
        mem_rsp_err    = rv ? mem_err(rsp_addr) : 1'b0;
        if (pend && pend_wait > 0) pend_wait--;
        #1;
        check("inst_valid", inst_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            check("inst_pc", inst_pc, m_fifo[0].pc);
            check("inst", inst, m_fifo[0].data);
            check("inst_err", inst_err, m_fifo[0].err);
        end
        if (mem_req_valid) begin
            check("req_addr", mem_req_addr, m_next_pc);
            check("req_credit", {m_out, m_halt, m_fifo.size() < DEPTH}, 3'b001);
        end
        hs  = mem_req_valid && ready_in;
        pop = (m_fifo.size() != 0) && iready_in && !redir;
        if (pop) begin
            e.pc = inst_pc; e.data = inst; e.err = inst_err;
            pop_log.push_back(e);
            m_fifo.pop_front();
        end
        if (rv) begin
            pend = 1'b0;
            if (!m_stale && !redir) begin
                e.pc = m_out_pc; e.data = mem_data(m_out_pc); e.err = mem_err(m_out_pc);
                m_fifo.push_back(e);
                if (e.err) m_halt = 1'b1;
            end
            m_out = 1'b0;
        end
        if (hs) begin
            hs_log.push_back(mem_req_addr);
            m_out     = 1'b1;
            m_stale   = 1'b0;
            m_out_pc  = m_next_pc;
            m_next_pc = m_next_pc + 32'd4;
            pend      = 1'b1;
            pend_wait = lat - 1;
            rsp_addr  = mem_req_addr;
        end
        if (redir) begin
            m_fifo.delete();
            m_next_pc = {redir_pc[31:2], 2'b00};
            m_halt    = 1'b0;
            if (m_out) m_stale = 1'b1;
        end
        @(posedge clk);
        #1;
        redir = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        redirect_valid = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
        inst_ready = 1'b0; mem_req_ready = 1'b0; redirect_pc = '0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_req_addr", mem_req_addr, RESET_PC);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_inst_err", inst_err, 0);
        m_fifo.delete();
        m_next_pc = RESET_PC;
        m_out = 1'b0; m_stale = 1'b0; m_halt = 1'b0;
        pend = 1'b0; redir = 1'b0;
        hs_log.delete();
        pop_log.delete();
        rst = 1'b0;
    endtask

    task automatic run_until_hs(input int n, input int bound);
        int k = 0;
        while (hs_log.size() < n && k < bound) begin
            step();
            k++;
        end
        check("hs_timeout", hs_log.size() >= n, 1);
    endtask

    task automatic run_until_pops(input int n, input int bound);
        int k = 0;
        while (pop_log.size() < n && k < bound) begin
            step();
            k++;
        end
        check("pop_timeout", pop_log.size() >= n, 1);
    endtask

    initial begin
        // Sequential fetch after reset.
        do_reset(2);
        ready_in = 1'b1; iready_in = 1'b1; lat = 1;
        run_until_hs(3, 20);
        check("t1_addr0", hs_log[0], 32'h8000_0000);
        check("t1_addr1", hs_log[1], 32'h8000_0004);
        check("t1_addr2", hs_log[2], 32'h8000_0008);
        run_until_pops(2, 20);
        check("t1_pc0", pop_log[0].pc, 32'h8000_0000);
        check("t1_data0", pop_log[0].data, mem_data(32'h8000_0000));
        check("t1_pc1", pop_log[1].pc, 32'h8000_0004);
        check("t1_data1", pop_log[1].data, mem_data(32'h8000_0004));

        // Backpressure fills the FIFO, then one pop releases one credit.
        do_reset(1);
        ready_in = 1'b1; iready_in = 1'b0; lat = 1;
        repeat (30) step();
        check("t2_hs_count", hs_log.size(), 4);
        check("t2_req_idle", mem_req_valid, 0);
        check("t2_full_valid", inst_valid, 1);
        iready_in = 1'b1;
        step();
        iready_in = 1'b0;
        run_until_hs(5, 20);
        check("t2_addr4", hs_log[4], 32'h8000_0010);

        // Redirect while a response is in flight.
        do_reset(1);
        ready_in = 1'b1; iready_in = 1'b0; lat = 5;
        run_until_hs(2, 30);
        step();
        redir = 1'b1; redir_pc = 32'h8000_0103;
        step();
        check("t3_flushed", inst_valid, 0);
        lat = 1;
        run_until_hs(3, 30);
        check("t3_addr", hs_log[2], 32'h8000_0100);
        iready_in = 1'b1;
        run_until_pops(1, 20);
        check("t3_pc", pop_log[0].pc, 32'h8000_0100);
        iready_in = 1'b0;

        // Redirect coinciding with a response and a pop, two entries queued.
        do_reset(1);
        ready_in = 1'b1; iready_in = 1'b0; lat = 3;
        run_until_hs(3, 40);
        begin
            int k = 0;
            while (!(pend && pend_wait == 0) && k < 10) begin
                step();
                k++;
            end
        end
        check("t4_two_queued", inst_valid, 1);
        redir = 1'b1; redir_pc = 32'h8000_0200; iready_in = 1'b1;
        step();
        iready_in = 1'b0;
        check("t4_empty", inst_valid, 0);
        run_until_hs(4, 20);
        check("t4_addr", hs_log[3], 32'h8000_0200);

        // Fetch fault halts the stream until a redirect.
        do_reset(1);
        err_addr = 32'h8000_0008;
        ready_in = 1'b1; iready_in = 1'b0; lat = 1;
        repeat (30) step();
        check("t5_hs_count", hs_log.size(), 3);
        iready_in = 1'b1;
        step();
        step();
        iready_in = 1'b0;
        check("t5_err_pc", inst_pc, 32'h8000_0008);
        check("t5_err_flag", inst_err, 1);
        repeat (20) step();
        check("t5_halted", hs_log.size(), 3);
        check("t5_no_req", mem_req_valid, 0);
        redir = 1'b1; redir_pc = 32'h8000_0000;
        step();
        err_addr = 32'h1;
        run_until_hs(4, 20);
        check("t5_resume", hs_log[3], 32'h8000_0000);

        // Held request, address wrap, reset while waiting.
        do_reset(1);
        ready_in = 1'b0; iready_in = 1'b1; lat = 1;
        step();
        repeat (5) begin
            check("t6_hold_valid", mem_req_valid, 1);
            check("t6_hold_addr", mem_req_addr, 32'h8000_0000);
            step();
        end
        redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
        step();
        ready_in = 1'b1;
        run_until_hs(2, 20);
        check("t6_wrap0", hs_log[0], 32'hFFFF_FFFC);
        check("t6_wrap1", hs_log[1], 32'h0000_0000);
        lat = 5;
        run_until_hs(3, 20);
        step();
        do_reset(1);
        ready_in = 1'b1; lat = 1;
        run_until_hs(1, 20);
        check("t6_after_rst", hs_log[0], 32'h8000_0000);

        // Random traffic against the model.
        do_reset(1);
        rand_err = 1'b1;
        repeat (3000) begin
            ready_in  = ($urandom_range(0, 3) != 0);
            iready_in = ($urandom_range(0, 4) < 3);
            lat       = int'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) begin
                redir    = 1'b1;
                redir_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                       : 32'($urandom);
            end
            step();
        end
        check("rand_progress", hs_log.size() > 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
